// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial front end with one-word holding register
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             pend_full_q, pend_full_d;
   logic             accept;

   // Ready depends only on state, so upstream never sees a loop through din_valid.
   assign din_ready  = reset && !pend_full_q;
   assign sout_valid = (cnt_q != '0);
   assign sout       = sout_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign busy       = sout_valid || pend_full_q;
   assign accept     = din_valid && din_ready;

   always_comb begin
      shreg_d     = shreg_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      pend_full_d = pend_full_q;
      if (cnt_q <= CNT_ONE) begin
         // Last bit (or nothing) on the wire: reload now so the next word follows gaplessly.
         if (pend_full_q) begin
            shreg_d = pend_q;
            cnt_d   = CNT_FULL;
            if (accept) begin
               pend_d = din;
            end else begin
               pend_full_d = 1'b0;
            end
         end else if (accept) begin
            shreg_d = din;
            cnt_d   = CNT_FULL;
         end else begin
            cnt_d = '0;
         end
      end else begin
         shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
         cnt_d   = cnt_q - CNT_ONE;
         if (accept) begin
            pend_d      = din;
            pend_full_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg_q     <= '0;
         pend_q      <= '0;
         cnt_q       <= '0;
         pend_full_q <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         pend_full_q <= pend_full_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - bench for bit_serializer: directed tables, corner sequences, random vs bit-queue model
module tb_bit_serializer;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;
   logic m_ready, m_sout, m_sv, m_busy;
   logic l_ready, l_sout, l_sv, l_busy;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(m_ready), .sout(m_sout), .sout_valid(m_sv), .busy(m_busy));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
      .din_ready(l_ready), .sout(l_sout), .sout_valid(l_sv), .busy(l_busy));

   // Model: every bit still owed to the wire, in emission order; front is the current bit.
   bit mq[$];
   bit lq[$];

   int checks = 0;
   int errors = 0;
   logic s_m, s_l, v_m, v_l, r_m, b_m;
   bit   acc_last;
   int   n_acc, lows, cyc;
   bit   lows_en;
   logic [31:0] col;
   int   ncol, first_v, last_v;
   bit   prev_s;
   int   pairs;

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] exp_msb;
      logic [W-1:0] exp_lsb;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      bit exp_r, exp_v;
      @(negedge clk);
      if (!reset) begin
         mq.delete();
         lq.delete();
      end
      exp_r = reset && (mq.size() <= W);
      exp_v = (mq.size() > 0);
      chk("msb_din_ready", m_ready, exp_r);
      chk("lsb_din_ready", l_ready, exp_r);
      chk("msb_sout_valid", m_sv, exp_v);
      chk("lsb_sout_valid", l_sv, exp_v);
      chk("msb_busy", m_busy, exp_v);
      chk("lsb_busy", l_busy, exp_v);
      chk("msb_sout", m_sout, exp_v ? mq[0] : 1'b0);
      chk("lsb_sout", l_sout, exp_v ? lq[0] : 1'b0);
      s_m = m_sout; s_l = l_sout; v_m = m_sv; v_l = l_sv; r_m = m_ready; b_m = m_busy;
      if (lows_en && n_acc >= 1 && n_acc < 3 && !m_ready) lows++;
      if (v_m) begin
         col = {col[30:0], s_m};
         if (ncol == 0) first_v = cyc;
         last_v = cyc;
         ncol++;
      end
      if (s_m && prev_s) pairs++;
      prev_s = s_m;
      cyc++;
      @(posedge clk);
      acc_last = 1'b0;
      if (reset) begin
         acc_last = din_valid && exp_r;
         if (mq.size() > 0) void'(mq.pop_front());
         if (lq.size() > 0) void'(lq.pop_front());
         if (acc_last) begin
            n_acc++;
            for (int i = W - 1; i >= 0; i--) mq.push_back(din[i]);
            for (int i = 0; i < W; i++) lq.push_back(din[i]);
         end
      end
      #1;
   endtask

   task automatic send(input logic [W-1:0] w);
      din       = w;
      din_valid = 1'b1;
      for (int t = 0; t < 40; t++) begin
         step();
         if (acc_last) break;
      end
      chk("send_accept_timeout", acc_last, 1'b1);
   endtask

   task automatic clear_col();
      col = '0; ncol = 0; first_v = 0; last_v = 0;
   endtask

   initial begin
      tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
      tbl[1] = '{8'h01, 8'h01, 8'h80};
      tbl[2] = '{8'h80, 8'h80, 8'h01};
      tbl[3] = '{8'hF0, 8'hF0, 8'h0F};
      tbl[4] = '{8'h3C, 8'h3C, 8'h3C};
      tbl[5] = '{8'h12, 8'h12, 8'h48};
      n_acc = 0; lows = 0; lows_en = 1'b0; cyc = 0; prev_s = 1'b0; pairs = 0;
      clear_col();

      // Reset held with din_valid high: nothing accepted, all outputs low.
      reset = 1'b0; din_valid = 1'b1; din = 8'hA5;
      #1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("rst_din_ready", r_m, 1'b0);
         chk("rst_sout_valid", v_m, 1'b0);
         chk("rst_sout", s_m, 1'b0);
         chk("rst_busy", b_m, 1'b0);
      end
      reset = 1'b1; din_valid = 1'b0;
      step();
      chk("post_rst_din_ready", r_m, 1'b1);
      chk("post_rst_no_word", v_m, 1'b0);

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] got_m, got_l;
         int nv;
         din = tbl[i].din; din_valid = 1'b1;
         step();
         din_valid = 1'b0; din = W'($urandom);
         got_m = '0; got_l = '0; nv = 0;
         for (int b = 0; b < W; b++) begin
            step();
            got_m = {got_m[W-2:0], s_m};
            got_l = {got_l[W-2:0], s_l};
            if (v_m) nv++;
         end
         chk("tbl_msb_bits", got_m, tbl[i].exp_msb);
         chk("tbl_lsb_bits", got_l, tbl[i].exp_lsb);
         chk("tbl_valid_cycles", nv, W);
         step();
         chk("tbl_idle_after", {v_m, b_m, s_m}, 3'b000);
      end

      // Streaming with din_valid held high.
      clear_col(); n_acc = 0; lows = 0; lows_en = 1'b1;
      send(8'hFF); send(8'h03); send(8'h81);
      din_valid = 1'b0; lows_en = 1'b0;
      for (int i = 0; i < 30; i++) step();
      chk("stream_bits", col[23:0], 24'hFF0381);
      chk("stream_nvalid", ncol, 24);
      chk("stream_gapless", last_v - first_v + 1, 24);
      chk("stream_ready_low", lows, 7);

      // Reset mid-word with a word pending.
      send(8'hF0); send(8'h0F);
      din_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      chk("midrst_sout_valid", v_m, 1'b0);
      chk("midrst_sout", s_m, 1'b0);
      chk("midrst_busy", b_m, 1'b0);
      step();
      reset = 1'b1;
      clear_col();
      send(8'hAA);
      din_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("midrst_resume_bits", col[7:0], 8'hAA);
      chk("midrst_resume_nvalid", ncol, 8);

      // Downstream '11' pair count over 0x60, 0x00 and trailing idle.
      pairs = 0; prev_s = 1'b0;
      send(8'h60); send(8'h00);
      din_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("chain_pairs", pairs, 1);

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) != 0);
         din_valid = ($urandom_range(0, 3) != 0);
         din       = W'($urandom);
         step();
      end
      reset = 1'b1; din_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
